// File: rtl/id_ex_stage.sv
// ID/EX pipeline register with load-use hazard detection, one-cycle ID->EX latency.
// A hold freezes all state; a flush or load-use hazard registers a bubble (ctrl = 0) and bumps its counter.
module id_ex_stage #(
  parameter int DATA_W = 32,
  parameter int CNT_W  = 16
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [4:0]        id_regRs,
  input  logic [4:0]        id_regRt,
  input  logic [4:0]        id_regRd,
  input  logic              id_usesRt,
  input  logic [DATA_W-1:0] id_readData1,
  input  logic [DATA_W-1:0] id_readData2,
  input  logic [DATA_W-1:0] id_signExt,
  input  logic [9:0]        id_ctrl,
  input  logic              flush,
  input  logic              hold,
  output logic [4:0]        ID_EX_regRs,
  output logic [4:0]        ID_EX_regRt,
  output logic [4:0]        ID_EX_regRd,
  output logic [DATA_W-1:0] ID_EX_readData1,
  output logic [DATA_W-1:0] ID_EX_readData2,
  output logic [DATA_W-1:0] ID_EX_signExt,
  output logic [9:0]        ID_EX_ctrl,
  output logic              pcWrite,
  output logic              IF_ID_write,
  output logic [CNT_W-1:0]  stall_count,
  output logic [CNT_W-1:0]  flush_count
);

  localparam int MEMREAD_BIT = 8;

  typedef struct packed {
    logic [4:0]        rs;
    logic [4:0]        rt;
    logic [4:0]        rd;
    logic [DATA_W-1:0] rd1;
    logic [DATA_W-1:0] rd2;
    logic [DATA_W-1:0] imm;
    logic [9:0]        ctrl;
  } idex_t;

  idex_t            stage_q, stage_d, id_pkt;
  logic [CNT_W-1:0] stall_cnt_q, stall_cnt_d;
  logic [CNT_W-1:0] flush_cnt_q, flush_cnt_d;
  logic             lu_haz;
  logic             front_en;

  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
    return (&v) ? v : v + CNT_W'(1);
  endfunction

  always_comb begin
    id_pkt.rs   = id_regRs;
    id_pkt.rt   = id_regRt;
    id_pkt.rd   = id_regRd;
    id_pkt.rd1  = id_readData1;
    id_pkt.rd2  = id_readData2;
    id_pkt.imm  = id_signExt;
    id_pkt.ctrl = id_ctrl;
  end

  // $0 is hard-wired zero, so a load targeting it can never feed a consumer.
  always_comb begin
    lu_haz = stage_q.ctrl[MEMREAD_BIT] && (stage_q.rt != 5'd0) &&
             ((stage_q.rt == id_regRs) || (id_usesRt && (stage_q.rt == id_regRt)));
  end

  // A taken branch discards the dependent instruction anyway, so flush lets the front end advance.
  always_comb begin
    if (reset) begin
      front_en = 1'b1;
    end else begin
      front_en = !hold && !(lu_haz && !flush);
    end
  end

  assign pcWrite     = front_en;
  assign IF_ID_write = front_en;

  always_comb begin
    stage_d     = stage_q;
    stall_cnt_d = stall_cnt_q;
    flush_cnt_d = flush_cnt_q;
    if (!hold) begin
      stage_d = id_pkt;
      if (flush) begin
        stage_d.ctrl = '0;
        flush_cnt_d  = sat_inc(flush_cnt_q);
      end else if (lu_haz) begin
        stage_d.ctrl = '0;
        stall_cnt_d  = sat_inc(stall_cnt_q);
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      stage_q     <= '0;
      stall_cnt_q <= '0;
      flush_cnt_q <= '0;
    end else begin
      stage_q     <= stage_d;
      stall_cnt_q <= stall_cnt_d;
      flush_cnt_q <= flush_cnt_d;
    end
  end

  assign ID_EX_regRs     = stage_q.rs;
  assign ID_EX_regRt     = stage_q.rt;
  assign ID_EX_regRd     = stage_q.rd;
  assign ID_EX_readData1 = stage_q.rd1;
  assign ID_EX_readData2 = stage_q.rd2;
  assign ID_EX_signExt   = stage_q.imm;
  assign ID_EX_ctrl      = stage_q.ctrl;
  assign stall_count     = stall_cnt_q;
  assign flush_count     = flush_cnt_q;

  // The bubble clears memRead, so a single load can never stall twice in a row.
  a_one_bubble: assert property (@(posedge clk) disable iff (reset)
    (lu_haz && !hold) |=> !lu_haz);

endmodule

// File: tb/tb_id_ex_stage.sv
// Randomized and directed bench for id_ex_stage against a rule-level reference model.
module tb_id_ex_stage;
  localparam int DW  = 32;
  localparam int CW  = 8;
  localparam int SAT = (1 << CW) - 1;
  localparam logic [9:0] LW = 10'h360;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic          reset = 1'b1;
  logic [4:0]    id_regRs = '0, id_regRt = '0, id_regRd = '0;
  logic          id_usesRt = 1'b0;
  logic [DW-1:0] id_readData1 = '0, id_readData2 = '0, id_signExt = '0;
  logic [9:0]    id_ctrl = '0;
  logic          flush = 1'b0, hold = 1'b0;
  logic [4:0]    ID_EX_regRs, ID_EX_regRt, ID_EX_regRd;
  logic [DW-1:0] ID_EX_readData1, ID_EX_readData2, ID_EX_signExt;
  logic [9:0]    ID_EX_ctrl;
  logic          pcWrite, IF_ID_write;
  logic [CW-1:0] stall_count, flush_count;

  id_ex_stage #(.DATA_W(DW), .CNT_W(CW)) dut (
    .clk(clk), .reset(reset),
    .id_regRs(id_regRs), .id_regRt(id_regRt), .id_regRd(id_regRd), .id_usesRt(id_usesRt),
    .id_readData1(id_readData1), .id_readData2(id_readData2), .id_signExt(id_signExt),
    .id_ctrl(id_ctrl), .flush(flush), .hold(hold),
    .ID_EX_regRs(ID_EX_regRs), .ID_EX_regRt(ID_EX_regRt), .ID_EX_regRd(ID_EX_regRd),
    .ID_EX_readData1(ID_EX_readData1), .ID_EX_readData2(ID_EX_readData2),
    .ID_EX_signExt(ID_EX_signExt), .ID_EX_ctrl(ID_EX_ctrl),
    .pcWrite(pcWrite), .IF_ID_write(IF_ID_write),
    .stall_count(stall_count), .flush_count(flush_count)
  );

  int n_checks = 0;
  int n_fail   = 0;

  // Reference model: what EX should see, plus plain integer counters.
  logic [4:0]    m_rs = '0, m_rt = '0, m_rd = '0;
  logic [DW-1:0] m_a = '0, m_b = '0, m_imm = '0;
  logic [9:0]    m_ctrl = '0;
  int            m_stall = 0, m_flush = 0;
  bit            m_known = 1'b0;

  function automatic bit m_haz();
    return m_ctrl[8] && (m_rt != 0) && ((m_rt == id_regRs) || (id_usesRt && (m_rt == id_regRt)));
  endfunction

  function automatic bit m_enable();
    if (reset) return 1'b1;
    return !hold && !(m_haz() && !flush);
  endfunction

  task automatic step();
    bit haz;
    @(posedge clk);
    haz = m_haz();
    if (reset) begin
      m_rs = 0; m_rt = 0; m_rd = 0; m_a = 0; m_b = 0; m_imm = 0; m_ctrl = 0;
      m_stall = 0; m_flush = 0; m_known = 1'b1;
    end else if (!hold) begin
      m_rs = id_regRs; m_rt = id_regRt; m_rd = id_regRd;
      m_a = id_readData1; m_b = id_readData2; m_imm = id_signExt;
      if (flush) begin
        m_ctrl = 0; m_known = 1'b0;
        m_flush = (m_flush < SAT) ? m_flush + 1 : SAT;
      end else if (haz) begin
        m_ctrl = 0; m_known = 1'b0;
        m_stall = (m_stall < SAT) ? m_stall + 1 : SAT;
      end else begin
        m_ctrl = id_ctrl; m_known = 1'b1;
      end
    end
    #1;
  endtask

  task automatic drive(input logic [4:0] rs, input logic [4:0] rt, input logic [4:0] rd,
                       input bit uses, input logic [DW-1:0] a, input logic [DW-1:0] b,
                       input logic [DW-1:0] imm, input logic [9:0] ctrl, input bit fl, input bit hd);
    id_regRs = rs; id_regRt = rt; id_regRd = rd; id_usesRt = uses;
    id_readData1 = a; id_readData2 = b; id_signExt = imm; id_ctrl = ctrl;
    flush = fl; hold = hd;
    #2;
  endtask

  task automatic drive_load(input logic [4:0] rt);
    drive(5'd1, rt, 5'd9, 1'b0, $urandom, $urandom, $urandom, LW, 1'b0, 1'b0);
  endtask

  task automatic test_reset();
    reset = 1'b1;
    drive(5'd7, 5'd8, 5'd9, 1'b1, 32'hDEAD, 32'hBEEF, 32'h1234, 10'h3FF, 1'b1, 1'b1);
    n_checks++; if (pcWrite !== 1'b1) begin n_fail++; $display("FAIL reset_pcWrite got %b want 1", pcWrite); end
    n_checks++; if (IF_ID_write !== 1'b1) begin n_fail++; $display("FAIL reset_ifid got %b want 1", IF_ID_write); end
    step(); step();
    reset = 1'b0;
    n_checks++; if (ID_EX_ctrl !== 10'h0) begin n_fail++; $display("FAIL reset_ctrl got %h want 0", ID_EX_ctrl); end
    n_checks++; if (ID_EX_regRs !== 5'd0) begin n_fail++; $display("FAIL reset_rs got %0d want 0", ID_EX_regRs); end
    n_checks++; if (ID_EX_readData1 !== '0) begin n_fail++; $display("FAIL reset_rd1 got %h want 0", ID_EX_readData1); end
    n_checks++; if (stall_count !== '0) begin n_fail++; $display("FAIL reset_stall got %0d want 0", stall_count); end
    n_checks++; if (flush_count !== '0) begin n_fail++; $display("FAIL reset_flush got %0d want 0", flush_count); end
  endtask

  task automatic test_normal();
    drive(5'd3, 5'd4, 5'd5, 1'b1, 32'h11, 32'h22, 32'h33, 10'h201, 1'b0, 1'b0);
    n_checks++; if (pcWrite !== 1'b1) begin n_fail++; $display("FAIL normal_pcWrite got %b want 1", pcWrite); end
    step();
    n_checks++; if (ID_EX_regRs !== 5'd3) begin n_fail++; $display("FAIL normal_rs got %0d want 3", ID_EX_regRs); end
    n_checks++; if (ID_EX_regRt !== 5'd4) begin n_fail++; $display("FAIL normal_rt got %0d want 4", ID_EX_regRt); end
    n_checks++; if (ID_EX_readData1 !== 32'h11) begin n_fail++; $display("FAIL normal_rd1 got %h want 11", ID_EX_readData1); end
    n_checks++; if (ID_EX_ctrl !== 10'h201) begin n_fail++; $display("FAIL normal_ctrl got %h want 201", ID_EX_ctrl); end
    n_checks++; if (pcWrite !== 1'b1) begin n_fail++; $display("FAIL normal_pcWrite2 got %b want 1", pcWrite); end
  endtask

  task automatic test_load_use_rs();
    drive_load(5'd5);
    step();
    drive(5'd5, 5'd6, 5'd7, 1'b1, 32'hA, 32'hB, 32'hC, 10'h202, 1'b0, 1'b0);
    n_checks++; if (pcWrite !== 1'b0) begin n_fail++; $display("FAIL lu_pcWrite got %b want 0", pcWrite); end
    n_checks++; if (IF_ID_write !== 1'b0) begin n_fail++; $display("FAIL lu_ifid got %b want 0", IF_ID_write); end
    step();
    n_checks++; if (ID_EX_ctrl !== 10'h0) begin n_fail++; $display("FAIL lu_bubble_ctrl got %h want 0", ID_EX_ctrl); end
    n_checks++; if (stall_count !== CW'(1)) begin n_fail++; $display("FAIL lu_stall got %0d want 1", stall_count); end
    n_checks++; if (pcWrite !== 1'b1) begin n_fail++; $display("FAIL lu_release got %b want 1", pcWrite); end
    step();
    n_checks++; if (ID_EX_ctrl !== 10'h202) begin n_fail++; $display("FAIL lu_reentry_ctrl got %h want 202", ID_EX_ctrl); end
    n_checks++; if (ID_EX_regRs !== 5'd5) begin n_fail++; $display("FAIL lu_reentry_rs got %0d want 5", ID_EX_regRs); end
  endtask

  task automatic test_rt_gating();
    int ss;
    drive_load(5'd7); step();
    ss = m_stall;
    drive(5'd2, 5'd7, 5'd3, 1'b0, 32'h1, 32'h2, 32'h3, 10'h0A0, 1'b0, 1'b0);
    n_checks++; if (pcWrite !== 1'b1) begin n_fail++; $display("FAIL rt_unused_pcWrite got %b want 1", pcWrite); end
    step();
    n_checks++; if (ID_EX_ctrl !== 10'h0A0) begin n_fail++; $display("FAIL rt_unused_ctrl got %h want 0a0", ID_EX_ctrl); end
    n_checks++; if (stall_count !== CW'(ss)) begin n_fail++; $display("FAIL rt_unused_stall got %0d want %0d", stall_count, ss); end
    drive_load(5'd7); step();
    drive(5'd2, 5'd7, 5'd3, 1'b1, 32'h1, 32'h2, 32'h3, 10'h0A0, 1'b0, 1'b0);
    n_checks++; if (pcWrite !== 1'b0) begin n_fail++; $display("FAIL rt_used_pcWrite got %b want 0", pcWrite); end
    step();
    n_checks++; if (ID_EX_ctrl !== 10'h0) begin n_fail++; $display("FAIL rt_used_ctrl got %h want 0", ID_EX_ctrl); end
    n_checks++; if (stall_count !== CW'(ss + 1)) begin n_fail++; $display("FAIL rt_used_stall got %0d want %0d", stall_count, ss + 1); end
    drive_load(5'd0); step();
    drive(5'd0, 5'd0, 5'd3, 1'b1, 32'h1, 32'h2, 32'h3, 10'h0A0, 1'b0, 1'b0);
    n_checks++; if (pcWrite !== 1'b1) begin n_fail++; $display("FAIL r0_pcWrite got %b want 1", pcWrite); end
    step();
    n_checks++; if (ID_EX_ctrl !== 10'h0A0) begin n_fail++; $display("FAIL r0_ctrl got %h want 0a0", ID_EX_ctrl); end
  endtask

  task automatic test_flush_vs_hazard();
    int ss, sf;
    drive_load(5'd5); step();
    ss = m_stall; sf = m_flush;
    drive(5'd5, 5'd5, 5'd1, 1'b1, 32'h5, 32'h6, 32'h7, 10'h202, 1'b1, 1'b0);
    n_checks++; if (pcWrite !== 1'b1) begin n_fail++; $display("FAIL fvh_pcWrite got %b want 1", pcWrite); end
    step();
    n_checks++; if (ID_EX_ctrl !== 10'h0) begin n_fail++; $display("FAIL fvh_ctrl got %h want 0", ID_EX_ctrl); end
    n_checks++; if (flush_count !== CW'(sf + 1)) begin n_fail++; $display("FAIL fvh_flush got %0d want %0d", flush_count, sf + 1); end
    n_checks++; if (stall_count !== CW'(ss)) begin n_fail++; $display("FAIL fvh_stall got %0d want %0d", stall_count, ss); end
    flush = 1'b0;
  endtask

  task automatic test_hold();
    int ss, sf;
    drive(5'd4, 5'd6, 5'd8, 1'b1, 32'hAAAA5555, 32'h12345678, 32'hFFFF0000, 10'h123, 1'b0, 1'b0);
    step();
    ss = m_stall; sf = m_flush;
    for (int i = 0; i < 3; i++) begin
      drive($urandom, $urandom, $urandom, 1'b1, $urandom, $urandom, $urandom, $urandom, 1'b1, 1'b1);
      n_checks++; if (pcWrite !== 1'b0) begin n_fail++; $display("FAIL hold_pcWrite[%0d] got %b want 0", i, pcWrite); end
      step();
      n_checks++; if (ID_EX_ctrl !== 10'h123) begin n_fail++; $display("FAIL hold_ctrl[%0d] got %h want 123", i, ID_EX_ctrl); end
      n_checks++; if (ID_EX_readData1 !== 32'hAAAA5555) begin n_fail++; $display("FAIL hold_rd1[%0d] got %h want aaaa5555", i, ID_EX_readData1); end
      n_checks++; if (ID_EX_regRt !== 5'd6) begin n_fail++; $display("FAIL hold_rt[%0d] got %0d want 6", i, ID_EX_regRt); end
      n_checks++; if (flush_count !== CW'(sf) || stall_count !== CW'(ss)) begin
        n_fail++; $display("FAIL hold_counts[%0d] got %0d/%0d want %0d/%0d", i, flush_count, stall_count, sf, ss);
      end
    end
    drive($urandom, $urandom, $urandom, 1'b1, $urandom, $urandom, $urandom, $urandom, 1'b1, 1'b0);
    n_checks++; if (pcWrite !== 1'b1) begin n_fail++; $display("FAIL hold_drop_pcWrite got %b want 1", pcWrite); end
    step();
    n_checks++; if (ID_EX_ctrl !== 10'h0) begin n_fail++; $display("FAIL hold_drop_ctrl got %h want 0", ID_EX_ctrl); end
    n_checks++; if (flush_count !== CW'(sf + 1)) begin n_fail++; $display("FAIL hold_drop_flush got %0d want %0d", flush_count, sf + 1); end
    flush = 1'b0;
  endtask

  task automatic test_random();
    logic [9:0] c;
    for (int i = 0; i < 400; i++) begin
      reset = ($urandom_range(0, 49) == 0);
      c = $urandom;
      c[8] = ($urandom_range(0, 1) == 1);
      drive($urandom_range(0, 3), $urandom_range(0, 3), $urandom, $urandom_range(0, 1),
            $urandom, $urandom, $urandom, c,
            $urandom_range(0, 9) == 0, $urandom_range(0, 9) == 0);
      n_checks++; if (pcWrite !== m_enable() || IF_ID_write !== m_enable()) begin
        n_fail++; $display("FAIL rnd_enable[%0d] got %b/%b want %b", i, pcWrite, IF_ID_write, m_enable());
      end
      step();
      n_checks++; if (ID_EX_ctrl !== m_ctrl) begin n_fail++; $display("FAIL rnd_ctrl[%0d] got %h want %h", i, ID_EX_ctrl, m_ctrl); end
      n_checks++; if (stall_count !== CW'(m_stall) || flush_count !== CW'(m_flush)) begin
        n_fail++; $display("FAIL rnd_counts[%0d] got %0d/%0d want %0d/%0d", i, stall_count, flush_count, m_stall, m_flush);
      end
      if (m_known) begin
        n_checks++;
        if (ID_EX_regRs !== m_rs || ID_EX_regRt !== m_rt || ID_EX_regRd !== m_rd ||
            ID_EX_readData1 !== m_a || ID_EX_readData2 !== m_b || ID_EX_signExt !== m_imm) begin
          n_fail++; $display("FAIL rnd_fields[%0d] got rs%0d rt%0d a%h want rs%0d rt%0d a%h",
                             i, ID_EX_regRs, ID_EX_regRt, ID_EX_readData1, m_rs, m_rt, m_a);
        end
      end
    end
    reset = 1'b0; flush = 1'b0; hold = 1'b0;
  endtask

  task automatic test_saturation();
    reset = 1'b1; step(); reset = 1'b0;
    for (int i = 0; i < SAT + 5; i++) begin
      drive_load(5'd5); step();
      drive(5'd5, 5'd2, 5'd3, 1'b1, $urandom, $urandom, $urandom, 10'h202, 1'b0, 1'b0); step();
    end
    n_checks++; if (stall_count !== CW'(SAT)) begin n_fail++; $display("FAIL sat_stall got %0d want %0d", stall_count, SAT); end
    drive_load(5'd5); step();
    drive(5'd5, 5'd2, 5'd3, 1'b1, $urandom, $urandom, $urandom, 10'h202, 1'b0, 1'b0);
    n_checks++; if (pcWrite !== 1'b0) begin n_fail++; $display("FAIL sat_pcWrite got %b want 0", pcWrite); end
    step();
    n_checks++; if (stall_count !== CW'(SAT)) begin n_fail++; $display("FAIL sat_stall_hold got %0d want %0d", stall_count, SAT); end
    for (int i = 0; i < SAT + 3; i++) begin
      drive($urandom, $urandom, $urandom, 1'b1, $urandom, $urandom, $urandom, $urandom, 1'b1, 1'b0); step();
    end
    n_checks++; if (flush_count !== CW'(SAT)) begin n_fail++; $display("FAIL sat_flush got %0d want %0d", flush_count, SAT); end
    flush = 1'b0;
  endtask

  task automatic test_reset_mid_stall();
    drive_load(5'd5); step();
    drive(5'd5, 5'd2, 5'd3, 1'b1, 32'h77, 32'h88, 32'h99, 10'h202, 1'b0, 1'b0);
    n_checks++; if (pcWrite !== 1'b0) begin n_fail++; $display("FAIL rms_stall got %b want 0", pcWrite); end
    reset = 1'b1; #1;
    n_checks++; if (pcWrite !== 1'b1) begin n_fail++; $display("FAIL rms_reset_pcWrite got %b want 1", pcWrite); end
    step();
    reset = 1'b0; #1;
    n_checks++; if (ID_EX_ctrl !== 10'h0 || ID_EX_regRs !== 5'd0 || ID_EX_readData1 !== '0) begin
      n_fail++; $display("FAIL rms_regs got ctrl%h rs%0d a%h want 0", ID_EX_ctrl, ID_EX_regRs, ID_EX_readData1);
    end
    n_checks++; if (stall_count !== '0 || flush_count !== '0) begin
      n_fail++; $display("FAIL rms_counts got %0d/%0d want 0/0", stall_count, flush_count);
    end
    n_checks++; if (pcWrite !== 1'b1) begin n_fail++; $display("FAIL rms_pcWrite_after got %b want 1", pcWrite); end
  endtask

  initial begin
    test_reset();
    test_normal();
    test_load_use_rs();
    test_rt_gating();
    test_flush_vs_hazard();
    test_hold();
    test_random();
    test_saturation();
    test_reset_mid_stall();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
